// File: rtl/mem_arbiter.sv
// Purpose : shares one synchronous RAM between the CPU memory port and the loader/debug port.
// Latency : write ack 2 cycles after the request is sampled; read ack 2+RD_LAT cycles.
// Backpress: requests are sampled only while idle; a losing requester waits at its level request.
//
// Ports:
//   clk, res                       clock, synchronous active-high reset
//   cpu_req/we/addr/wdata          CPU request (level), held until cpu_ack
//   cpu_rdata, cpu_ack             CPU read data register, one-cycle completion pulse
//   ldr_req/we/addr/wdata          loader request (level), held until ldr_ack
//   ldr_rdata, ldr_ack             loader read data register, one-cycle completion pulse
//   mem_en/we/addr/wdata, mem_rdata  RAM side; mem_rdata valid RD_LAT cycles after mem_en
//   busy, owner                    arbiter not idle; current/last grant (0 = CPU, 1 = loader)
module mem_arbiter #(
  parameter int AW           = 8,
  parameter int DW           = 32,
  parameter int RD_LAT       = 1,
  parameter int CPU_PRIORITY = 0
) (
  input  logic          clk,
  input  logic          res,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_ack,
  input  logic          ldr_req,
  input  logic          ldr_we,
  input  logic [AW-1:0] ldr_addr,
  input  logic [DW-1:0] ldr_wdata,
  output logic [DW-1:0] ldr_rdata,
  output logic          ldr_ack,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          owner
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // WAIT runs from WAIT_INIT down to zero inclusive, i.e. RD_LAT cycles.
  localparam logic [2:0] WAIT_INIT     = 3'(RD_LAT - 1);
  localparam logic       CPU_WINS_TIES = (CPU_PRIORITY != 0);

  state_t        state_q,     state_d;
  logic          owner_q,     owner_d;
  logic          last_ldr_q,  last_ldr_d;   // round-robin pointer: 1 = loader got the last grant
  logic          we_q,        we_d;
  logic [AW-1:0] addr_q,      addr_d;
  logic [DW-1:0] wdata_q,     wdata_d;
  logic [2:0]    cnt_q,       cnt_d;
  logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DW-1:0] ldr_rdata_q, ldr_rdata_d;

  logic          grant_ldr;

  // Loader wins when it is alone, or on a round-robin tie after a CPU grant.
  always_comb begin
    grant_ldr = ldr_req & (~cpu_req | (~CPU_WINS_TIES & ~last_ldr_q));
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_ldr_d  = last_ldr_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    cpu_rdata_d = cpu_rdata_q;
    ldr_rdata_d = ldr_rdata_q;

    case (state_q)
      S_IDLE: begin
        if (cpu_req | ldr_req) begin
          owner_d    = grant_ldr;
          last_ldr_d = grant_ldr;
          we_d       = grant_ldr ? ldr_we    : cpu_we;
          addr_d     = grant_ldr ? ldr_addr  : cpu_addr;
          wdata_d    = grant_ldr ? ldr_wdata : cpu_wdata;
          state_d    = S_ISSUE;
        end
      end

      S_ISSUE: begin
        if (we_q) begin
          state_d = S_DONE;
        end else begin
          cnt_d   = WAIT_INIT;
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        if (cnt_q != 3'd0) begin
          cnt_d = cnt_q - 3'd1;
        end else begin
          // Last WAIT cycle is exactly RD_LAT cycles after the mem_en cycle.
          if (owner_q) begin
            ldr_rdata_d = mem_rdata;
          end else begin
            cpu_rdata_d = mem_rdata;
          end
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state_q     <= S_IDLE;
      owner_q     <= 1'b0;
      last_ldr_q  <= 1'b1;   // CPU wins the first tie after reset
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cnt_q       <= 3'd0;
      cpu_rdata_q <= '0;
      ldr_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_ldr_q  <= last_ldr_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      cpu_rdata_q <= cpu_rdata_d;
      ldr_rdata_q <= ldr_rdata_d;
    end
  end

  // All outputs come straight from state, so none of them depends on the request inputs.
  assign mem_en    = (state_q == S_ISSUE);
  assign mem_we    = (state_q == S_ISSUE) & we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign cpu_ack   = (state_q == S_DONE) & ~owner_q;
  assign ldr_ack   = (state_q == S_DONE) &  owner_q;
  assign cpu_rdata = cpu_rdata_q;
  assign ldr_rdata = ldr_rdata_q;
  assign busy      = (state_q != S_IDLE);
  assign owner     = owner_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: instance 0 uses RD_LAT=1 with round-robin ties,
// instance 1 uses RD_LAT=4 with CPU priority. Each instance has its own RAM model.
module tb_mem_arbiter;
  localparam int AW = 8;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  logic [1:0]    res;
  logic          cpu_req, cpu_we, ldr_req, ldr_we;
  logic [AW-1:0] cpu_addr, ldr_addr;
  logic [DW-1:0] cpu_wdata, ldr_wdata;

  logic [DW-1:0] cpu_rdata [2];
  logic [DW-1:0] ldr_rdata [2];
  logic [DW-1:0] mem_wdata [2];
  logic [DW-1:0] mem_rdata [2];
  logic [AW-1:0] mem_addr  [2];
  logic [1:0]    cpu_ack, ldr_ack, mem_en, mem_we, busy, owner;

  mem_arbiter #(.AW(AW), .DW(DW), .RD_LAT(1), .CPU_PRIORITY(0)) dut_a (
    .clk(clk), .res(res[0]),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata[0]), .cpu_ack(cpu_ack[0]),
    .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
    .ldr_rdata(ldr_rdata[0]), .ldr_ack(ldr_ack[0]),
    .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]),
    .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0]),
    .busy(busy[0]), .owner(owner[0])
  );

  mem_arbiter #(.AW(AW), .DW(DW), .RD_LAT(4), .CPU_PRIORITY(1)) dut_b (
    .clk(clk), .res(res[1]),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata[1]), .cpu_ack(cpu_ack[1]),
    .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
    .ldr_rdata(ldr_rdata[1]), .ldr_ack(ldr_ack[1]),
    .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]),
    .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1]),
    .busy(busy[1]), .owner(owner[1])
  );

  // RAM models: read data travels down a delay line; outside its valid slot the
  // read bus carries random junk so a mistimed capture is visible.
  logic [DW-1:0] ram  [2][256];
  logic [DW-1:0] pdat [2][4];
  logic [3:0]    pvld [2];
  logic [DW-1:0] junk [2];
  logic          bd_we;
  logic [AW-1:0] bd_addr;
  logic [DW-1:0] bd_dat;

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (bd_we) ram[k][bd_addr] <= bd_dat;
      else if (mem_en[k] && mem_we[k]) ram[k][mem_addr[k]] <= mem_wdata[k];
      pdat[k][0] <= ram[k][mem_addr[k]];
      for (int j = 1; j < 4; j++) pdat[k][j] <= pdat[k][j-1];
      pvld[k] <= {pvld[k][2:0], mem_en[k] & ~mem_we[k]};
      junk[k] <= $urandom;
    end
  end

  always_comb begin
    mem_rdata[0] = pvld[0][0] ? pdat[0][0] : junk[0];
    mem_rdata[1] = pvld[1][3] ? pdat[1][3] : junk[1];
  end

  // Reference memory contents, maintained by the bench only.
  logic [DW-1:0] mdl_mem [2][256];

  task automatic reset_only(input int k);
    cpu_req = 1'b0;
    ldr_req = 1'b0;
    res = 2'b11;
    repeat (2) @(negedge clk);
    res[k] = 1'b0;
  endtask

  task automatic test_reset();
    res = 2'b11;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      n_checks++; if ({cpu_ack[k], ldr_ack[k], mem_en[k], mem_we[k], busy[k], owner[k]} !== 6'b0) begin
        n_fail++; $display("FAIL reset_ctrl k=%0d got %b expected 000000", k,
                           {cpu_ack[k], ldr_ack[k], mem_en[k], mem_we[k], busy[k], owner[k]});
      end else n_pass++;
      n_checks++; if (cpu_rdata[k] !== '0 || ldr_rdata[k] !== '0) begin
        n_fail++; $display("FAIL reset_rdata k=%0d got %h/%h expected 0", k, cpu_rdata[k], ldr_rdata[k]);
      end else n_pass++;
      n_checks++; if (mem_addr[k] !== '0 || mem_wdata[k] !== '0) begin
        n_fail++; $display("FAIL reset_mem k=%0d got %h/%h expected 0", k, mem_addr[k], mem_wdata[k]);
      end else n_pass++;
    end
  endtask

  task automatic test_cpu_read();
    reset_only(0);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h10; cpu_wdata = 32'h0;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      n_checks++; if (mem_en[0] !== (i == 1)) begin
        n_fail++; $display("FAIL rd_mem_en i=%0d got %b expected %b", i, mem_en[0], (i == 1));
      end else n_pass++;
      n_checks++; if (cpu_ack[0] !== (i == 3) || ldr_ack[0] !== 1'b0) begin
        n_fail++; $display("FAIL rd_ack i=%0d got cpu=%b ldr=%b expected cpu=%b ldr=0", i, cpu_ack[0], ldr_ack[0], (i == 3));
      end else n_pass++;
      if (i == 1) begin
        n_checks++; if (mem_addr[0] !== 8'h10 || mem_we[0] !== 1'b0) begin
          n_fail++; $display("FAIL rd_issue got addr=%h we=%b expected addr=10 we=0", mem_addr[0], mem_we[0]);
        end else n_pass++;
      end
      if (i == 3) begin
        n_checks++; if (cpu_rdata[0] !== 32'hDEADBEEF) begin
          n_fail++; $display("FAIL rd_data got %h expected deadbeef", cpu_rdata[0]);
        end else n_pass++;
        cpu_req = 1'b0;
      end
    end
  endtask

  task automatic test_ldr_write();
    reset_only(0);
    ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 8'h05; ldr_wdata = 32'h12345678;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      if (i == 1) begin
        n_checks++; if (mem_en[0] !== 1'b1 || mem_we[0] !== 1'b1 || mem_addr[0] !== 8'h05 ||
                        mem_wdata[0] !== 32'h12345678 || owner[0] !== 1'b1) begin
          n_fail++; $display("FAIL wr_issue got en=%b we=%b addr=%h data=%h own=%b expected 1 1 05 12345678 1",
                             mem_en[0], mem_we[0], mem_addr[0], mem_wdata[0], owner[0]);
        end else n_pass++;
      end
      n_checks++; if (ldr_ack[0] !== (i == 2) || cpu_ack[0] !== 1'b0) begin
        n_fail++; $display("FAIL wr_ack i=%0d got ldr=%b cpu=%b expected ldr=%b cpu=0", i, ldr_ack[0], cpu_ack[0], (i == 2));
      end else n_pass++;
      if (i == 2) ldr_req = 1'b0;
    end
    n_checks++; if (mem_addr[0] !== 8'h05 || mem_wdata[0] !== 32'h12345678 || ldr_rdata[0] !== '0 || busy[0] !== 1'b0) begin
      n_fail++; $display("FAIL wr_hold got addr=%h data=%h ldr_rdata=%h busy=%b expected 05 12345678 0 0",
                         mem_addr[0], mem_wdata[0], ldr_rdata[0], busy[0]);
    end else n_pass++;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h05;
    for (int j = 1; j <= 4; j++) begin
      @(negedge clk);
      n_checks++; if (cpu_ack[0] !== (j == 3)) begin
        n_fail++; $display("FAIL wr_readback_ack j=%0d got %b expected %b", j, cpu_ack[0], (j == 3));
      end else n_pass++;
      if (j == 3) begin
        n_checks++; if (cpu_rdata[0] !== 32'h12345678) begin
          n_fail++; $display("FAIL wr_readback got %h expected 12345678", cpu_rdata[0]);
        end else n_pass++;
        cpu_req = 1'b0;
      end
    end
  endtask

  task automatic test_tie_rr();
    reset_only(0);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h30; cpu_wdata = 32'hAAAA0030;
    ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 8'h31; ldr_wdata = 32'h55550031;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      n_checks++; if (cpu_ack[0] !== (i == 2 || i == 8) || ldr_ack[0] !== (i == 5 || i == 11)) begin
        n_fail++; $display("FAIL rr_ack i=%0d got cpu=%b ldr=%b expected cpu=%b ldr=%b", i, cpu_ack[0], ldr_ack[0],
                           (i == 2 || i == 8), (i == 5 || i == 11));
      end else n_pass++;
      if (i % 3 == 1) begin
        n_checks++; if (mem_en[0] !== 1'b1 || owner[0] !== (i == 4 || i == 10)) begin
          n_fail++; $display("FAIL rr_grant i=%0d got en=%b owner=%b expected en=1 owner=%b", i, mem_en[0], owner[0], (i == 4 || i == 10));
        end else n_pass++;
      end
      if (i == 11) begin cpu_req = 1'b0; ldr_req = 1'b0; end
    end
    n_checks++; if (busy[0] !== 1'b0) begin
      n_fail++; $display("FAIL rr_idle got busy=%b expected 0", busy[0]);
    end else n_pass++;
  endtask

  task automatic test_priority();
    reset_only(1);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h34; cpu_wdata = 32'h11110034;
    ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 8'h35; ldr_wdata = 32'h22220035;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      n_checks++; if (cpu_ack[1] !== (i % 3 == 2) || ldr_ack[1] !== 1'b0) begin
        n_fail++; $display("FAIL pri_ack i=%0d got cpu=%b ldr=%b expected cpu=%b ldr=0", i, cpu_ack[1], ldr_ack[1], (i % 3 == 2));
      end else n_pass++;
      if (i == 11) begin cpu_req = 1'b0; ldr_req = 1'b0; end
    end
  endtask

  task automatic test_rd_lat4();
    reset_only(1);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h20;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      n_checks++; if (mem_en[1] !== (i == 1) || busy[1] !== (i <= 6) || cpu_ack[1] !== (i == 6)) begin
        n_fail++; $display("FAIL lat4_ctrl i=%0d got en=%b busy=%b ack=%b expected %b %b %b", i,
                           mem_en[1], busy[1], cpu_ack[1], (i == 1), (i <= 6), (i == 6));
      end else n_pass++;
      n_checks++; if (cpu_rdata[1] !== ((i >= 6) ? 32'hCAFEF00D : 32'h0)) begin
        n_fail++; $display("FAIL lat4_data i=%0d got %h expected %h", i, cpu_rdata[1], (i >= 6) ? 32'hCAFEF00D : 32'h0);
      end else n_pass++;
      if (i == 6) cpu_req = 1'b0;
    end
  endtask

  task automatic test_reset_abort();
    reset_only(0);
    ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 8'h10;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (i == 2) begin
        n_checks++; if (busy[0] !== 1'b1 || owner[0] !== 1'b1) begin
          n_fail++; $display("FAIL abort_wait got busy=%b owner=%b expected 1 1", busy[0], owner[0]);
        end else n_pass++;
        res[0] = 1'b1; ldr_req = 1'b0;
      end
      if (i == 3) begin
        n_checks++; if ({cpu_ack[0], ldr_ack[0], mem_en[0], mem_we[0], busy[0], owner[0]} !== 6'b0 ||
                        mem_addr[0] !== '0 || mem_wdata[0] !== '0 || ldr_rdata[0] !== '0 || cpu_rdata[0] !== '0) begin
          n_fail++; $display("FAIL abort_zero got ctrl=%b addr=%h wd=%h lrd=%h crd=%h expected all 0",
                             {cpu_ack[0], ldr_ack[0], mem_en[0], mem_we[0], busy[0], owner[0]},
                             mem_addr[0], mem_wdata[0], ldr_rdata[0], cpu_rdata[0]);
        end else n_pass++;
        res[0] = 1'b0;
      end
      if (i >= 4) begin
        n_checks++; if (ldr_ack[0] !== 1'b0 || busy[0] !== 1'b0) begin
          n_fail++; $display("FAIL abort_quiet i=%0d got ack=%b busy=%b expected 0 0", i, ldr_ack[0], busy[0]);
        end else n_pass++;
      end
    end
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h50; cpu_wdata = 32'h0BAD0050;
    ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 8'h51; ldr_wdata = 32'h0BAD0051;
    for (int j = 1; j <= 6; j++) begin
      @(negedge clk);
      n_checks++; if (cpu_ack[0] !== (j == 2) || ldr_ack[0] !== (j == 5)) begin
        n_fail++; $display("FAIL abort_tie j=%0d got cpu=%b ldr=%b expected %b %b", j, cpu_ack[0], ldr_ack[0], (j == 2), (j == 5));
      end else n_pass++;
      if (j == 2) cpu_req = 1'b0;
      if (j == 5) ldr_req = 1'b0;
    end
  endtask

  task automatic test_drop_req();
    reset_only(0);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h40; cpu_wdata = 32'h77770040;
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      n_checks++; if (cpu_ack[0] !== (i == 2) || mem_en[0] !== (i == 1) || busy[0] !== (i <= 2) || ldr_ack[0] !== 1'b0) begin
        n_fail++; $display("FAIL drop i=%0d got ack=%b en=%b busy=%b lack=%b expected %b %b %b 0", i,
                           cpu_ack[0], mem_en[0], busy[0], ldr_ack[0], (i == 2), (i == 1), (i <= 2));
      end else n_pass++;
      if (i == 1) cpu_req = 1'b0;
    end
  endtask

  // Transaction-level model: each requester issues random transactions and holds
  // them until acked; the model grants by the arbitration rule when the arbiter is
  // free and predicts ack cycle, issue cycle and returned data.
  task automatic test_random(input int k, input int ncyc);
    int lat, idle_at, ack_at, grant_c, own, w;
    bit pri, last_ldr;
    bit act [2];
    bit gnt [2];
    bit twe [2];
    bit req_now [2];
    logic [AW-1:0] tad [2];
    logic [DW-1:0] twd [2];
    logic [DW-1:0] exp_rd [2];
    logic [DW-1:0] rd_val;
    lat = (k == 0) ? 1 : 4;
    pri = (k != 0);
    reset_only(k);
    for (int p = 0; p < 2; p++) begin
      act[p] = 0; gnt[p] = 0; twe[p] = 0; req_now[p] = 0; tad[p] = '0; twd[p] = '0; exp_rd[p] = '0;
    end
    idle_at = 0; ack_at = -10; grant_c = -10; own = 0; last_ldr = 1'b1; rd_val = '0;
    for (int c = 0; c < ncyc; c++) begin
      if (c == ack_at && !twe[own]) exp_rd[own] = rd_val;
      n_checks++; if (cpu_ack[k] !== (c == ack_at && own == 0) || ldr_ack[k] !== (c == ack_at && own == 1)) begin
        n_fail++; $display("FAIL rnd_ack k=%0d c=%0d got cpu=%b ldr=%b expected %b %b", k, c, cpu_ack[k], ldr_ack[k],
                           (c == ack_at && own == 0), (c == ack_at && own == 1));
      end else n_pass++;
      n_checks++; if (busy[k] !== (c < idle_at) || mem_en[k] !== (c == grant_c + 1) || owner[k] !== 1'(own)) begin
        n_fail++; $display("FAIL rnd_ctrl k=%0d c=%0d got busy=%b en=%b own=%b expected %b %b %0d", k, c,
                           busy[k], mem_en[k], owner[k], (c < idle_at), (c == grant_c + 1), own);
      end else n_pass++;
      n_checks++; if (cpu_rdata[k] !== exp_rd[0] || ldr_rdata[k] !== exp_rd[1]) begin
        n_fail++; $display("FAIL rnd_rdata k=%0d c=%0d got %h/%h expected %h/%h", k, c,
                           cpu_rdata[k], ldr_rdata[k], exp_rd[0], exp_rd[1]);
      end else n_pass++;
      if (c == grant_c + 1) begin
        n_checks++; if (mem_addr[k] !== tad[own] || mem_we[k] !== twe[own] || (twe[own] && mem_wdata[k] !== twd[own])) begin
          n_fail++; $display("FAIL rnd_issue k=%0d c=%0d got addr=%h we=%b wd=%h expected %h %b %h", k, c,
                             mem_addr[k], mem_we[k], mem_wdata[k], tad[own], twe[own], twd[own]);
        end else n_pass++;
      end
      for (int p = 0; p < 2; p++) begin
        if (c == ack_at && own == p) begin act[p] = 0; gnt[p] = 0; end
        if (!act[p]) begin
          if ($urandom_range(0, 2) == 0) begin
            act[p] = 1; req_now[p] = 1;
            twe[p] = 1'($urandom_range(0, 1));
            tad[p] = 8'(8'h80 + $urandom_range(0, 15));
            twd[p] = $urandom;
          end else req_now[p] = 0;
        end else if (gnt[p] && $urandom_range(0, 3) == 0) req_now[p] = 0;
      end
      cpu_req = req_now[0]; cpu_we = twe[0]; cpu_addr = tad[0]; cpu_wdata = twd[0];
      ldr_req = req_now[1]; ldr_we = twe[1]; ldr_addr = tad[1]; ldr_wdata = twd[1];
      if (c >= idle_at && (req_now[0] || req_now[1])) begin
        if (req_now[0] && req_now[1]) w = pri ? 0 : (last_ldr ? 0 : 1);
        else w = req_now[1] ? 1 : 0;
        gnt[w] = 1; last_ldr = (w == 1); own = w; grant_c = c;
        if (twe[w]) begin
          mdl_mem[k][tad[w]] = twd[w];
          ack_at = c + 2;
        end else begin
          rd_val = mdl_mem[k][tad[w]];
          ack_at = c + 2 + lat;
        end
        idle_at = ack_at + 1;
      end
      @(negedge clk);
    end
    cpu_req = 1'b0; ldr_req = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  initial begin
    res = 2'b11;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    ldr_req = 1'b0; ldr_we = 1'b0; ldr_addr = '0; ldr_wdata = '0;
    bd_we = 1'b1;
    for (int a = 0; a < 256; a++) begin
      bd_addr = 8'(a);
      bd_dat  = $urandom;
      if (a == 16) bd_dat = 32'hDEADBEEF;
      if (a == 32) bd_dat = 32'hCAFEF00D;
      mdl_mem[0][a] = bd_dat;
      mdl_mem[1][a] = bd_dat;
      @(negedge clk);
    end
    bd_we = 1'b0;
    test_reset();
    test_cpu_read();
    test_ldr_write();
    test_tie_rr();
    test_priority();
    test_rd_lat4();
    test_reset_abort();
    test_drop_req();
    test_random(0, 800);
    test_random(1, 800);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single unified instruction/data memory of the multicycle MIPS core between two requesters: the CPU memory port and the program loader/debug port.
- Sequences each access through a fixed issue/wait/done protocol with a configurable memory read latency.
- Returns a one-cycle ack with registered read data to the winning requester.
- Sits between the core's memory address mux (i_or_d path) and the synchronous RAM.

Parameters:
- AW, 8: word address width.
- DW, 32: data width.
- RD_LAT, 1: memory read latency in cycles after the mem_en cycle. Legal range 1..7.
- CPU_PRIORITY, 0: 0 = round-robin on ties; 1 = CPU always wins ties.

Ports:
- clk  in  1  clock, all state updates on rising edge
- res  in  1  reset, synchronous, active-high
- cpu_req  in  1  CPU access request, level
- cpu_we  in  1  CPU write enable (1 = write)
- cpu_addr  in  AW  CPU word address
- cpu_wdata  in  DW  CPU write data
- cpu_rdata  out  DW  CPU read data, registered
- cpu_ack  out  1  CPU transaction complete, one-cycle pulse
- ldr_req  in  1  loader access request, level
- ldr_we  in  1  loader write enable
- ldr_addr  in  AW  loader word address
- ldr_wdata  in  DW  loader write data
- ldr_rdata  out  DW  loader read data, registered
- ldr_ack  out  1  loader transaction complete, one-cycle pulse
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable, qualified by mem_en
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, valid RD_LAT cycles after the mem_en cycle
- busy  out  1  high whenever state != IDLE
- owner  out  1  current or last grant: 0 = CPU, 1 = loader

Behaviour:
- Reset (res=1 sampled at an edge):
  - state=IDLE; all outputs 0 (including both rdata registers, mem_addr and mem_wdata).
  - Round-robin pointer = loader, so the CPU wins the first tie.
  - Reset mid-transaction aborts it: no ack is issued and mem_en is 0 from the next cycle.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - Requests are sampled only in IDLE.
  - If any req is high: choose a winner; latch owner, we, addr and wdata from the winner; go to ISSUE.
  - Otherwise stay in IDLE.
- Arbitration:
  - A single requester always wins.
  - Tie with CPU_PRIORITY=0: grant the port opposite to the last grant, then update the pointer.
  - Tie with CPU_PRIORITY=1: grant the CPU.
  - No preemption once a grant is made.
- ISSUE (exactly one cycle):
  - mem_en=1; mem_we=latched we; mem_addr and mem_wdata driven from the latched values.
  - Write: go to DONE.
  - Read: go to WAIT and load the wait counter with RD_LAT-1.
- WAIT:
  - mem_en=0.
  - While the counter is nonzero, decrement it.
  - When the counter is 0, capture mem_rdata into the owner's rdata register and go to DONE.
  - WAIT therefore lasts RD_LAT cycles.
- DONE (one cycle): assert the owner's ack for exactly one cycle; go to IDLE.
- Latency (req first high in IDLE at cycle t):
  - Write ack at t+2.
  - Read ack at t+2+RD_LAT.
  - Minimum spacing between consecutive issues: 3 cycles for writes, 3+RD_LAT for reads.
- Requester rules:
  - Hold req, we, addr and wdata stable until ack.
  - Dropping req before ack does not cancel the transaction; the ack is still pulsed.
  - req still high in the cycle after ack (IDLE) is a new request.
- Hold behaviour:
  - mem_addr and mem_wdata hold their latched values until the next grant.
  - Each rdata register holds until that port's next read completes.
  - Write transactions never alter the rdata registers.
- Ack exclusivity: cpu_ack and ldr_ack are never high together; neither is high outside DONE.
- Both reqs rising in the same IDLE cycle follows the tie rule; the loser is served on the next IDLE in which it is still requesting.

Test Plan:
- Reset then CPU read (addr=0x10, RD_LAT=1, RAM[0x10]=0xDEADBEEF), req at t: mem_en pulses at t+1; cpu_ack and cpu_rdata=0xDEADBEEF at t+3; ldr_ack stays 0.
- Loader write (addr=0x05, wdata=0x12345678) at t: mem_en=mem_we=1 at t+1 with matching addr/data; ldr_ack at t+2. A following CPU read of 0x05 returns 0x12345678.
- Both reqs held continuously, writes, CPU_PRIORITY=0: grants alternate CPU, LDR, CPU, LDR; acks 3 cycles apart. With CPU_PRIORITY=1: only the CPU is ever granted.
- RD_LAT=4, CPU read at t: WAIT lasts 4 cycles; cpu_ack at t+6. mem_rdata changed after the capture cycle does not alter cpu_rdata.
- res pulsed during WAIT of a loader read: no ldr_ack ever; all outputs 0 next cycle; busy=0. A subsequent tie grants the CPU first.
- CPU drops req the cycle after ISSUE of a write: cpu_ack still pulses once at t+2; the arbiter returns to IDLE and makes no further grant.
